// File: rtl/lot_pkg.sv
// Shared types and constants for the two-beam gate sensor driver.
// The REJ state exists only when LOT_DRV_GUARD_EN is defined.
package lot_pkg;

  localparam logic DIR_ENTRY = 1'b0;
  localparam logic DIR_EXIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH1  = 3'd1,
    ST_PH2  = 3'd2,
    ST_PH3  = 3'd3,
    ST_GAP  = 3'd4
`ifdef LOT_DRV_GUARD_EN
    , ST_REJ = 3'd5
`endif
  } state_t;

  // {a,b} per phase; both directions walk the beams in Gray order
  localparam logic [1:0] AB_IDLE      = 2'b00;
  localparam logic [1:0] AB_ENTRY_PH1 = 2'b10;
  localparam logic [1:0] AB_ENTRY_PH2 = 2'b11;
  localparam logic [1:0] AB_ENTRY_PH3 = 2'b01;
  localparam logic [1:0] AB_EXIT_PH1  = 2'b01;
  localparam logic [1:0] AB_EXIT_PH2  = 2'b11;
  localparam logic [1:0] AB_EXIT_PH3  = 2'b10;

  function automatic logic [1:0] phase_ab(input logic dir, input state_t ph);
    logic [1:0] ab;
    ab = AB_IDLE;
    case (ph)
      ST_PH1:  ab = (dir == DIR_ENTRY) ? AB_ENTRY_PH1 : AB_EXIT_PH1;
      ST_PH2:  ab = (dir == DIR_ENTRY) ? AB_ENTRY_PH2 : AB_EXIT_PH2;
      ST_PH3:  ab = (dir == DIR_ENTRY) ? AB_ENTRY_PH3 : AB_EXIT_PH3;
      default: ab = AB_IDLE;
    endcase
    return ab;
  endfunction

endpackage

// File: rtl/lot_sensor_driver_timer.sv
// Dwell timer: loadable down-counter whose terminal count advances the phase FSM.
module lot_dwell_timer #(
  parameter int DWELL_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tc
);

  localparam int W = $clog2(DWELL_CYCLES + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(DWELL_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/lot_sensor_driver.sv
// Two-beam gate sensor waveform generator with a shadow occupancy count.
// Optional guard (LOT_DRV_GUARD_EN) rejects entry when full and exit when empty.
module lot_sensor_driver
  import lot_pkg::*;
#(
  parameter int DWELL_CYCLES = 2,
  parameter int CNT_W        = 8,
  parameter int MAX_COUNT    = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic             req_dir,
  output logic             req_ready,
  output logic             a,
  output logic             b,
  output logic             busy,
  output logic             done,
  output logic             rejected,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_COUNT);

  // Handshake: a request transfers on a rising edge where req_valid & req_ready;
  // req_ready is high only in IDLE, so a pending request must be held until then.
  state_t st;
  logic   dir_q;
  logic   accept;
  logic   tmr_load;
  logic   tmr_tc;

  assign req_ready = (st == ST_IDLE);
  assign busy      = (st != ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign state     = st;

  always_comb begin
    tmr_load = 1'b0;
    if (accept) begin
      tmr_load = 1'b1;
    end else if (tmr_tc && (st == ST_PH1 || st == ST_PH2 || st == ST_PH3)) begin
      tmr_load = 1'b1;
    end
  end

  lot_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (tmr_load),
    .tc   (tmr_tc)
  );

`ifdef LOT_DRV_GUARD_EN
  logic guard_hit;
  assign guard_hit = (req_dir == DIR_ENTRY) ? (count == MAX_C) : (count == '0);
`else
  assign rejected = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= ST_IDLE;
      dir_q <= DIR_ENTRY;
      a     <= 1'b0;
      b     <= 1'b0;
      done  <= 1'b0;
      count <= '0;
`ifdef LOT_DRV_GUARD_EN
      rejected <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef LOT_DRV_GUARD_EN
      rejected <= 1'b0;
`endif
      case (st)
        ST_IDLE: begin
          if (accept) begin
            dir_q <= req_dir;
`ifdef LOT_DRV_GUARD_EN
            if (guard_hit) begin
              st <= ST_REJ;
            end else begin
              st     <= ST_PH1;
              {a, b} <= phase_ab(req_dir, ST_PH1);
            end
`else
            st     <= ST_PH1;
            {a, b} <= phase_ab(req_dir, ST_PH1);
`endif
          end
        end
        ST_PH1: begin
          if (tmr_tc) begin
            st     <= ST_PH2;
            {a, b} <= phase_ab(dir_q, ST_PH2);
          end
        end
        ST_PH2: begin
          if (tmr_tc) begin
            st     <= ST_PH3;
            {a, b} <= phase_ab(dir_q, ST_PH3);
          end
        end
        ST_PH3: begin
          if (tmr_tc) begin
            st     <= ST_GAP;
            {a, b} <= phase_ab(dir_q, ST_GAP);
          end
        end
        ST_GAP: begin
          if (tmr_tc) begin
            st   <= ST_IDLE;
            done <= 1'b1;
            // Count moves with done and saturates at both ends
            if (dir_q == DIR_ENTRY) begin
              if (count != MAX_C) count <= count + CNT_W'(1);
            end else begin
              if (count != '0) count <= count - CNT_W'(1);
            end
          end
        end
`ifdef LOT_DRV_GUARD_EN
        ST_REJ: begin
          st       <= ST_IDLE;
          done     <= 1'b1;
          rejected <= 1'b1;
        end
`endif
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lot_sensor_driver.sv
// Bench for lot_sensor_driver: table of passes plus reset/hold corner sequences,
// with a per-cycle expected queue and a Gray-step monitor on a/b.
module tb_lot_sensor_driver;

  logic       clk;
  logic       reset;
  logic       rv1, rd1, rv2, rd2;
  logic       rdy1, a1, b1, busy1, done1, rej1;
  logic       rdy2, a2, b2, busy2, done2, rej2;
  logic [7:0] cnt1, cnt2;
  logic [2:0] st1, st2;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [5:0] exp_q[$];
  logic [7:0] model_cnt[2];
  logic [7:0] max_c[2];

  typedef struct {
    int         sel;
    logic       dir;
    logic [7:0] cnt;
  } vec_t;

  vec_t tab[13];

  lot_sensor_driver #(.DWELL_CYCLES(2), .CNT_W(8), .MAX_COUNT(255)) dut (
    .clk(clk), .reset(reset), .req_valid(rv1), .req_dir(rd1), .req_ready(rdy1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .rejected(rej1), .count(cnt1),
    .state(st1)
  );

  lot_sensor_driver #(.DWELL_CYCLES(1), .CNT_W(8), .MAX_COUNT(3)) dut2 (
    .clk(clk), .reset(reset), .req_valid(rv2), .req_dir(rd2), .req_ready(rdy2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .rejected(rej2), .count(cnt2),
    .state(st2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] obs(input int sel);
    if (sel == 0) return {rdy1, a1, b1, busy1, done1, rej1};
    return {rdy2, a2, b2, busy2, done2, rej2};
  endfunction

  function automatic logic [7:0] cnt_of(input int sel);
    return (sel == 0) ? cnt1 : cnt2;
  endfunction

  // Reference beam pattern for phase 1..4 (4 = gap)
  function automatic logic [1:0] exp_ab(input logic dir, input int ph);
    if (dir == 1'b0) begin
      case (ph)
        1: return 2'b10;
        2: return 2'b11;
        3: return 2'b01;
        default: return 2'b00;
      endcase
    end
    case (ph)
      1: return 2'b01;
      2: return 2'b11;
      3: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Called right after a negedge; ends right after a negedge.
  task automatic run_pass(input int sel, input logic dir, input logic [7:0] exp_cnt,
                          input bit hold, input logic hold_dir);
    int         d;
    int         n;
    bit         rej;
    logic [7:0] mc;
    logic [5:0] e;
    d   = (sel == 0) ? 2 : 1;
    mc  = model_cnt[sel];
    rej = 1'b0;
`ifdef LOT_DRV_GUARD_EN
    if ((dir == 1'b0 && mc == max_c[sel]) || (dir == 1'b1 && mc == 8'd0)) rej = 1'b1;
`endif
    if (sel == 0) begin rv1 = 1'b1; rd1 = dir; end
    else begin rv2 = 1'b1; rd2 = dir; end
    check("ready_before_accept", 16'(obs(sel) >> 5), 16'd1);
    @(posedge clk);
    #1;
    if (hold) begin
      if (sel == 0) rd1 = hold_dir; else rd2 = hold_dir;
    end else begin
      if (sel == 0) rv1 = 1'b0; else rv2 = 1'b0;
    end
    if (rej) begin
      exp_q.push_back({1'b0, 2'b00, 1'b1, 1'b0, 1'b0});
      exp_q.push_back({1'b1, 2'b00, 1'b0, 1'b1, 1'b1});
    end else begin
      for (int ph = 1; ph <= 4; ph++)
        for (int k = 0; k < d; k++)
          exp_q.push_back({1'b0, exp_ab(dir, ph), 1'b1, 1'b0, 1'b0});
      exp_q.push_back({1'b1, 2'b00, 1'b0, 1'b1, 1'b0});
    end
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      check("pass_cycle", 16'(obs(sel)), 16'(e));
    end
    if (!rej) begin
      if (dir == 1'b0) begin
        if (mc != max_c[sel]) mc = mc + 8'd1;
      end else begin
        if (mc != 8'd0) mc = mc - 8'd1;
      end
    end
    model_cnt[sel] = mc;
    check("count_after_pass", 16'(cnt_of(sel)), 16'(exp_cnt));
  endtask

  logic [1:0] prev1 = 2'b00;
  logic [1:0] prev2 = 2'b00;

  always @(negedge clk) begin
    if (reset) begin
      prev1 = {a1, b1};
      prev2 = {a2, b2};
    end else begin
      if ({a1, b1} != prev1) check("gray_step_dut1", 16'($countones({a1, b1} ^ prev1)), 16'd1);
      if ({a2, b2} != prev2) check("gray_step_dut2", 16'($countones({a2, b2} ^ prev2)), 16'd1);
      prev1 = {a1, b1};
      prev2 = {a2, b2};
    end
  end

  initial begin
    tab[0]  = '{0, 1'b0, 8'd1};
    tab[1]  = '{0, 1'b0, 8'd2};
    tab[2]  = '{0, 1'b0, 8'd3};
    tab[3]  = '{0, 1'b1, 8'd2};
    tab[4]  = '{0, 1'b1, 8'd1};
    tab[5]  = '{0, 1'b1, 8'd0};
    tab[6]  = '{0, 1'b1, 8'd0};
    tab[7]  = '{0, 1'b0, 8'd1};
    tab[8]  = '{1, 1'b0, 8'd1};
    tab[9]  = '{1, 1'b0, 8'd2};
    tab[10] = '{1, 1'b0, 8'd3};
    tab[11] = '{1, 1'b0, 8'd3};
    tab[12] = '{1, 1'b1, 8'd2};
    model_cnt[0] = 8'd0;
    model_cnt[1] = 8'd0;
    max_c[0]     = 8'd255;
    max_c[1]     = 8'd3;

    reset = 1'b1;
    rv1 = 1'b0; rd1 = 1'b0; rv2 = 1'b0; rd2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_obs_dut1", 16'(obs(0)), 16'b100000);
    check("reset_obs_dut2", 16'(obs(1)), 16'b100000);
    check("reset_count_dut1", 16'(cnt1), 16'd0);
    check("reset_state_dut1", 16'(st1), 16'd0);
    check("reset_state_dut2", 16'(st2), 16'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_pass(tab[i].sel, tab[i].dir, tab[i].cnt, 1'b0, 1'b0);

    // Entry with an exit request held through the whole pass
    run_pass(0, 1'b0, 8'd2, 1'b1, 1'b1);
    run_pass(0, 1'b1, 8'd1, 1'b0, 1'b0);

    // Reset in the middle of PH2 aborts the pass before the next clock
    rv1 = 1'b1; rd1 = 1'b0;
    @(posedge clk);
    #1 rv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("ph2_before_reset", 16'(obs(0)), 16'b011100);
    #1 reset = 1'b1;
    #1;
    check("async_reset_obs", 16'(obs(0)), 16'b100000);
    check("async_reset_count", 16'(cnt1), 16'd0);
    model_cnt[0] = 8'd0;
    model_cnt[1] = 8'd0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    run_pass(0, 1'b0, 8'd1, 1'b0, 1'b0);

    // Back-to-back passes on the fast, small-capacity instance
    for (int i = 8; i < 13; i++) run_pass(tab[i].sel, tab[i].dir, tab[i].cnt, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
